// File: rtl/fp_result_pack.sv
// fp_result_pack: back end of the FP add/div/sqrt exception path.
// Stage 1 captures classification plus raw datapath result; stage 2 holds the
// packed IEEE double and per-op flags. Sticky flags accumulate on each transfer.
// Optional feature macro: FP_NAN_PROP_EN (propagate operand NaN payloads for
// non-invalid NaN results instead of emitting the canonical QNaN).
// Flag vector layout (MSB..LSB): {invalid, divzero, denorm, overflow, underflow, inexact}.
module fp_result_pack #(
    parameter int unsigned FLAG_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       raw_res,
    input  logic              sign_in,
    input  logic [2:0]        ztype,
    input  logic              invalid_in,
    input  logic              denorm_in,
    input  logic              of_in,
    input  logic              uf_in,
    input  logic              nx_in,
    input  logic [63:0]       op_a,
    input  logic [63:0]       op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       result,
    output logic [FLAG_W-1:0] res_flags,
    input  logic              clr_flags,
    output logic [FLAG_W-1:0] sticky_flags
);

    localparam logic [63:0] CanonNan = 64'h7FF8_0000_0000_0000;

    localparam int unsigned FlInvalid = 5;
    localparam int unsigned FlDivZero = 4;
    localparam int unsigned FlDenorm  = 3;

    // Stage 1 state
    logic        s1_valid_q, s1_valid_d;
    logic [63:0] s1_raw_q;
    logic        s1_sign_q;
    logic [2:0]  s1_ztype_q;
    logic        s1_inv_q;
    logic        s1_den_q;
    logic        s1_of_q;
    logic        s1_uf_q;
    logic        s1_nx_q;

    // Stage 2 state
    logic              s2_valid_q, s2_valid_d;
    logic [63:0]       result_q;
    logic [FLAG_W-1:0] res_flags_q;
    logic [FLAG_W-1:0] sticky_q, sticky_d;

    logic s1_load;
    logic s2_load;
    logic xfer;

    logic [63:0]       pack_res;
    logic [FLAG_W-1:0] pack_flags;
    logic [63:0]       nan_res;

    assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;
    assign s1_load  = in_valid & in_ready;
    // Stage 1 moves forward when stage 2 is empty or being drained this cycle
    assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    assign xfer     = s2_valid_q & out_ready;

`ifdef FP_NAN_PROP_EN
    logic [63:0] s1_op_a_q;
    logic [63:0] s1_op_b_q;
    logic        a_is_nan;
    logic [63:0] nan_src;

    // Operand capture for NaN payload propagation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_op_a_q <= '0;
            s1_op_b_q <= '0;
        end else if (s1_load) begin
            s1_op_a_q <= op_a;
            s1_op_b_q <= op_b;
        end
    end

    // Prefer op_a's payload, quieten whichever operand is chosen
    always_comb begin
        a_is_nan = (&s1_op_a_q[62:52]) & (|s1_op_a_q[51:0]);
        nan_src  = a_is_nan ? s1_op_a_q : s1_op_b_q;
        nan_res  = {nan_src[63:52], 1'b1, nan_src[50:0]};
    end
`else
    logic unused_ops;
    assign unused_ops = ^{op_a, op_b};
    assign nan_res    = CanonNan;
`endif

    // Valid/ready bookkeeping for both stages
    always_comb begin
        s1_valid_d = s1_load | (s1_valid_q & ~s2_load);
        s2_valid_d = s2_load | (s2_valid_q & ~out_ready);
    end

    // Stage 1 capture of classification and datapath result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_raw_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_ztype_q <= '0;
            s1_inv_q   <= 1'b0;
            s1_den_q   <= 1'b0;
            s1_of_q    <= 1'b0;
            s1_uf_q    <= 1'b0;
            s1_nx_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_raw_q   <= raw_res;
                s1_sign_q  <= sign_in;
                s1_ztype_q <= ztype;
                s1_inv_q   <= invalid_in;
                s1_den_q   <= denorm_in;
                s1_of_q    <= of_in;
                s1_uf_q    <= uf_in;
                s1_nx_q    <= nx_in;
            end
        end
    end

    // Class decode in priority order; rounder flags only survive for Normal results
    always_comb begin
        pack_res   = CanonNan;
        pack_flags = '0;
        if (s1_inv_q) begin
            pack_flags[FlInvalid] = 1'b1;
        end else if (s1_ztype_q[1:0] == 2'b01) begin
            pack_res = nan_res;
        end else if (s1_ztype_q == 3'b011) begin
            pack_res = {s1_sign_q, 63'b0};
        end else if (s1_ztype_q == 3'b010) begin
            pack_res = {s1_sign_q, 11'h7FF, 52'b0};
        end else if (s1_ztype_q == 3'b110) begin
            pack_res              = {s1_sign_q, 11'h7FF, 52'b0};
            pack_flags[FlDivZero] = 1'b1;
        end else if (s1_ztype_q[1:0] == 2'b00) begin
            pack_res        = s1_raw_q;
            pack_flags[2:0] = {s1_of_q, s1_uf_q, s1_nx_q};
        end else begin
            // Reserved code without an invalid from the classifier: treat as invalid
            pack_flags[FlInvalid] = 1'b1;
        end
        pack_flags[FlDenorm] = s1_den_q;
    end

    // Sticky update: a clear coincident with a transfer clears first, then ORs
    always_comb begin
        sticky_d = sticky_q;
        if (xfer) begin
            sticky_d = (clr_flags ? '0 : sticky_q) | res_flags_q;
        end else if (clr_flags) begin
            sticky_d = '0;
        end
    end

    // Stage 2 holds the packed result until downstream accepts it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q  <= 1'b0;
            result_q    <= '0;
            res_flags_q <= '0;
            sticky_q    <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            sticky_q   <= sticky_d;
            if (s2_load) begin
                result_q    <= pack_res;
                res_flags_q <= pack_flags;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign result       = result_q;
    assign res_flags    = res_flags_q;
    assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fp_result_pack.sv
// Directed bench for fp_result_pack: vector table plus hand-written sequences
// for backpressure, coincident clear, and mid-flight reset.
module tb_fp_result_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] raw_res;
    logic        sign_in;
    logic [2:0]  ztype;
    logic        invalid_in;
    logic        denorm_in;
    logic        of_in;
    logic        uf_in;
    logic        nx_in;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [5:0]  res_flags;
    logic        clr_flags;
    logic [5:0]  sticky_flags;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] raw;
        logic        sign;
        logic [2:0]  zt;
        logic        inv;
        logic        den;
        logic        of_;
        logic        uf;
        logic        nx;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_res;
        logic [5:0]  exp_flags;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    fp_result_pack #(.FLAG_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .raw_res      (raw_res),
        .sign_in      (sign_in),
        .ztype        (ztype),
        .invalid_in   (invalid_in),
        .denorm_in    (denorm_in),
        .of_in        (of_in),
        .uf_in        (uf_in),
        .nx_in        (nx_in),
        .op_a         (op_a),
        .op_b         (op_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .res_flags    (res_flags),
        .clr_flags    (clr_flags),
        .sticky_flags (sticky_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        raw_res    = v.raw;
        sign_in    = v.sign;
        ztype      = v.zt;
        invalid_in = v.inv;
        denorm_in  = v.den;
        of_in      = v.of_;
        uf_in      = v.uf;
        nx_in      = v.nx;
        op_a       = v.a;
        op_b       = v.b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until out_valid; returns cycles spent
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    // Issue one op and wait for it at the output, leaving it un-transferred
    task automatic issue_and_wait(input vec_t v, output int cyc);
        drive(v);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(cyc);
    endtask

    logic [5:0]  sticky_m;
    logic [63:0] nan4, nan9;
    logic [63:0] got[$];
    vec_t        w, va, vb;
    int          cyc, acc;
    logic        acc_now;

    initial begin
`ifdef FP_NAN_PROP_EN
        nan4 = 64'h7FF8_0000_0000_0123;
        nan9 = 64'hFFFC_0000_0000_0001;
`else
        nan4 = 64'h7FF8_0000_0000_0000;
        nan9 = 64'h7FF8_0000_0000_0000;
`endif
        //          raw                 sg zt      inv den of uf nx a                    b                    exp_res              flags
        vecs[0] = '{64'h3FF0000000000000, 0, 3'b000, 0, 0, 0, 0, 1, 64'h0, 64'h0,
                    64'h3FF0000000000000, 6'b000001};
        vecs[1] = '{64'h1234, 1, 3'b110, 0, 0, 1, 1, 1, 64'h0, 64'h0,
                    64'hFFF0000000000000, 6'b010000};
        vecs[2] = '{64'h1234, 0, 3'b011, 1, 0, 0, 0, 0, 64'h0, 64'h0,
                    64'h7FF8000000000000, 6'b100000};
        vecs[3] = '{64'h1234, 0, 3'b001, 0, 0, 0, 0, 0, 64'h7FF0000000000123, 64'h0,
                    nan4, 6'b000000};
        vecs[4] = '{64'h1234, 1, 3'b011, 0, 1, 0, 0, 1, 64'h0, 64'h0,
                    64'h8000000000000000, 6'b001000};
        vecs[5] = '{64'h1234, 0, 3'b010, 0, 0, 1, 0, 0, 64'h0, 64'h0,
                    64'h7FF0000000000000, 6'b000000};
        vecs[6] = '{64'h1234, 0, 3'b111, 0, 0, 1, 0, 0, 64'h0, 64'h0,
                    64'h7FF8000000000000, 6'b100000};
        vecs[7] = '{64'h4000000000000000, 0, 3'b100, 0, 0, 1, 1, 0, 64'h0, 64'h0,
                    64'h4000000000000000, 6'b000110};
        vecs[8] = '{64'h1234, 0, 3'b101, 0, 0, 0, 0, 1, 64'h3FF0000000000000,
                    64'hFFF4000000000001, nan9, 6'b000000};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        drive(vecs[0]);
        sticky_m  = '0;

        step();
        step();
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_res_flags", {58'b0, res_flags}, 64'd0);
        check("reset_sticky", {58'b0, sticky_flags}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("reset_in_ready", {63'b0, in_ready}, 64'd1);

        // Table-driven single ops with out_ready held high
        for (int i = 0; i < NV; i++) begin
            issue_and_wait(vecs[i], cyc);
            check($sformatf("vec%0d_latency", i), 64'(cyc), 64'd1);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
            check($sformatf("vec%0d_flags", i), {58'b0, res_flags}, {58'b0, vecs[i].exp_flags});
            sticky_m |= vecs[i].exp_flags;
            step();
            check($sformatf("vec%0d_sticky", i), {58'b0, sticky_flags}, {58'b0, sticky_m});
            check($sformatf("vec%0d_drained", i), {63'b0, out_valid}, 64'd0);
        end

        // clr_flags alone clears sticky
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("clr_alone_sticky", {58'b0, sticky_flags}, 64'd0);

        // Backpressure: four back-to-back requests, only two accepted
        va = vecs[0];
        va.raw = 64'h1111; va.nx = 1'b1; va.uf = 1'b0; va.of_ = 1'b0;
        vb = vecs[0];
        vb.raw = 64'h2222; vb.nx = 1'b0; vb.uf = 1'b1; vb.of_ = 1'b0;
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            drive(acc == 0 ? va : vb);
            if (acc >= 2) begin
                w = vb;
                w.raw = 64'h3333;
                drive(w);
            end
            in_valid = 1'b1;
            acc_now  = in_ready;
            step();
            if (acc_now) acc++;
        end
        in_valid = 1'b0;
        check("bp_accepts", 64'(acc), 64'd2);
        check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        check("bp_out_valid", {63'b0, out_valid}, 64'd1);
        check("bp_head_result", result, 64'h1111);
        check("bp_sticky_held", {58'b0, sticky_flags}, 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) got.push_back(result);
            step();
        end
        check("bp_count", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            check("bp_first", got[0], 64'h1111);
            check("bp_second", got[1], 64'h2222);
        end
        check("bp_sticky", {58'b0, sticky_flags}, 64'h3);

        // Clear coincident with a transfer
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        w = vecs[0];
        issue_and_wait(w, cyc);
        step();
        check("pre_sticky", {58'b0, sticky_flags}, 64'h1);
        w = vecs[0];
        w.nx = 1'b0; w.of_ = 1'b1;
        issue_and_wait(w, cyc);
        check("coinc_flags", {58'b0, res_flags}, 64'h4);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("coinc_sticky", {58'b0, sticky_flags}, 64'h4);

        // Reset mid-flight with two ops held in the pipe
        out_ready = 1'b0;
        w = vecs[1];
        drive(w);
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("mid_out_valid_before", {63'b0, out_valid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("mid_reset_sticky", {58'b0, sticky_flags}, 64'd0);
        step();
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (out_valid) acc++;
        end
        check("post_reset_no_output", 64'(acc), 64'd0);
        check("post_reset_sticky", {58'b0, sticky_flags}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/fp_result_pack.md
Name: fp_result_pack

Overview:
- Back end of the FP add/div/sqrt exception path: consumes result classification (Ztype, Invalid, Denorm) plus raw datapath result.
- Substitutes IEEE special values, emits the final 64-bit double with per-op flags, and maintains sticky exception flags.
- Two-stage valid/ready pipeline between the datapath and the writeback/FPSCR logic.

Parameters:
- FLAG_W, 6, width of flag vectors {invalid, divzero, denorm, overflow, underflow, inexact} (MSB..LSB); fixed at 6, parameter for readability only.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input op valid
- in_ready  out  1  block can accept input
- raw_res  in  64  datapath result (used when class is Normal)
- sign_in  in  1  sign for Inf/Zero results
- ztype  in  3  result type from exception classifier
- invalid_in  in  1  invalid-operation exception
- denorm_in  in  1  denormal operand seen
- of_in, uf_in, nx_in  in  1 each  overflow/underflow/inexact from rounder
- op_a, op_b  in  64 each  original operands (NaN propagation only)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  64  final double
- res_flags  out  6  flags of this op
- clr_flags  in  1  clear sticky flags
- sticky_flags  out  6  accumulated flags

Behaviour:
- Reset (async, active-high): both stage valids 0, out_valid=0, result=0, res_flags=0, sticky_flags=0. in_ready=1 one cycle after reset deasserts (combinational from stage state).
- Stage 1 registers inputs on in_valid&in_ready. Stage 2 holds the packed result. Latency 2 cycles, throughput 1/cycle when out_ready=1.
- in_ready = ~s1_valid | ~s2_valid | out_ready. Stage advances only if its successor is empty or draining. Data is never dropped or duplicated.
- out_valid held with result/res_flags stable until out_ready.
- Class decode (stage 1→2), priority order:
  1. invalid_in → QNaN 0x7FF8000000000000, flag invalid.
  2. ztype[1:0]=01 → QNaN, no invalid flag.
  3. ztype=011 → {sign_in,63'b0}.
  4. ztype=010 → {sign_in,0x7FF,52'b0}.
  5. ztype=110 → as 4 plus divzero flag.
  6. ztype[1:0]=00 → raw_res, flags of/uf/nx passed.
  7. Any other code (111 without invalid) → QNaN, invalid flag.
- of/uf/nx are forced 0 for non-Normal classes. denorm flag = denorm_in for all classes.
- Sticky update on out_valid&out_ready: sticky |= res_flags.
- clr_flags in the same cycle as a transfer: sticky = res_flags (clear first, then OR).
- clr_flags alone: sticky = 0.
- out_ready=0 indefinitely: pipeline fills (2 entries), then in_ready=0.
- reset mid-operation: all in-flight ops discarded, nothing reaches sticky.

Optional Feature:
- FP_NAN_PROP_EN defined: QNaN rule 2 propagates the operand payload instead of canonical NaN.
  - Use op_a if op_a is NaN, else op_b.
  - Quiet bit[51] forced 1; sign and payload kept.
  - Invalid-derived NaNs (rules 1, 7) remain canonical.
- FP_NAN_PROP_EN undefined: always canonical 0x7FF8000000000000; op_a/op_b unused.

Test Plan:
- ztype=000, raw_res=0x3FF0000000000000, nx_in=1, out_ready=1 → result 0x3FF0000000000000 two cycles later, res_flags=000001, sticky=000001.
- ztype=110, sign_in=1, invalid_in=0 → result 0xFFF0000000000000, res_flags=010000; then clr_flags alone → sticky=0.
- invalid_in=1, ztype=011 (sqrt of negative) → result 0x7FF8000000000000, res_flags=100000.
- Without FP_NAN_PROP_EN: ztype=001, op_a=0x7FF0000000000123 → 0x7FF8000000000000. With FP_NAN_PROP_EN: same stimulus → 0x7FF8000000000123.
- out_ready=0, four back-to-back in_valid → in_ready drops after 2 accepts. Release out_ready → exactly 2 results in order, sticky updated only on transfers.
- clr_flags coincident with transfer of an op with of_in=1 (pre-sticky 000001) → sticky=000100. Async reset asserted mid-flight → out_valid=0 immediately, sticky=0.
